// File: rtl/rgb_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// rgb_cmp_arbiter
//
// Round-robin arbiter and sequencer that time-shares one 2-bit RGB magnitude
// comparator (R = A>B, G = A==B, B = A<B) among NUM_REQ requesters. Each
// transaction latches the winner's operands onto the comparator, holds them
// for HOLD_CYCLES cycles, samples R/G/B and returns the result with a
// one-cycle ack to the winner.
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   HOLD_CYCLES  cycles the comparator inputs settle before sampling (1..15)
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   req              per-requester request level
//   req_a, req_b     2-bit operands per requester, requester i at [2i+1:2i]
//   ack              one-hot one-cycle completion pulse to the winner
//   done             one-cycle pulse; rgb_out and done_id valid with it
//   done_id          index of the completed requester
//   rgb_out          {R,G,B} sampled result, held until the next done
//   busy             high while a transaction is in DRIVE or SAMPLE
//   cmp_a0..cmp_b1   registered operand drive to the comparator
//   cmp_r/g/b        comparator outputs
//   err              (only with RGB_ONEHOT_CHECK_EN) sticky flag, set when a
//                    sampled {R,G,B} is not exactly one-hot; cleared by rst
//
// Optional feature macro: RGB_ONEHOT_CHECK_EN
// -----------------------------------------------------------------------------
module rgb_cmp_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [2*NUM_REQ-1:0]       req_a,
    input  logic [2*NUM_REQ-1:0]       req_b,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic [2:0]                 rgb_out,
    output logic                       busy,
    output logic                       cmp_a0,
    output logic                       cmp_a1,
    output logic                       cmp_b0,
    output logic                       cmp_b1,
    input  logic                       cmp_r,
    input  logic                       cmp_g,
    input  logic                       cmp_b
`ifdef RGB_ONEHOT_CHECK_EN
    ,
    output logic                       err
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   last_ptr;
    logic [ID_W-1:0]   win_q;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   cand;
    logic [3:0]        hold_cnt;
    logic [1:0]        op_a [NUM_REQ];
    logic [1:0]        op_b [NUM_REQ];

    // Unpack the flat operand buses so the winner can be selected by index.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = req_a[2*i +: 2];
            op_b[i] = req_b[2*i +: 2];
        end
    end

    // Rotating priority: scan from last_ptr+1 upward (wrapping). Walking the
    // offsets from farthest to nearest lets the nearest set bit overwrite,
    // so the first requester after last_ptr wins.
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = ID_W'((int'(last_ptr) + off) % NUM_REQ);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                // hold_cnt is loaded with HOLD_CYCLES, so leaving at 1 makes
                // DRIVE last exactly HOLD_CYCLES cycles.
                if (hold_cnt == 4'd1) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == DRIVE) || (state == SAMPLE);

    // Datapath: operand latch, hold counter, result capture and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ptr <= ID_W'(NUM_REQ - 1);
            win_q    <= '0;
            hold_cnt <= '0;
            cmp_a0   <= 1'b0;
            cmp_a1   <= 1'b0;
            cmp_b0   <= 1'b0;
            cmp_b1   <= 1'b0;
            rgb_out  <= '0;
            done     <= 1'b0;
            done_id  <= '0;
            ack      <= '0;
        end else begin
            done <= 1'b0;
            ack  <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        cmp_a1   <= op_a[win_idx][1];
                        cmp_a0   <= op_a[win_idx][0];
                        cmp_b1   <= op_b[win_idx][1];
                        cmp_b0   <= op_b[win_idx][0];
                        win_q    <= win_idx;
                        hold_cnt <= 4'(HOLD_CYCLES);
                    end
                end
                DRIVE: begin
                    hold_cnt <= hold_cnt - 4'd1;
                end
                SAMPLE: begin
                    rgb_out  <= {cmp_r, cmp_g, cmp_b};
                    done     <= 1'b1;
                    ack      <= NUM_REQ'(1) << win_q;
                    done_id  <= win_q;
                    last_ptr <= win_q;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RGB_ONEHOT_CHECK_EN
    logic rgb_onehot;
    assign rgb_onehot = ({cmp_r, cmp_g, cmp_b} == 3'b100) ||
                        ({cmp_r, cmp_g, cmp_b} == 3'b010) ||
                        ({cmp_r, cmp_g, cmp_b} == 3'b001);

    // Sticky: once a bad sample is seen, only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == SAMPLE && !rgb_onehot) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rgb_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rgb_cmp_arbiter
//
// Self-checking bench for rgb_cmp_arbiter (NUM_REQ=4, HOLD_CYCLES=1) with a
// behavioural comparator attached: R = A>B, G = A==B, B = A<B. Directed
// stimulus covers reset, a single request, round robin, an operand sweep,
// reset during a transaction and, with RGB_ONEHOT_CHECK_EN, the sticky err.
// -----------------------------------------------------------------------------
module tb_rgb_cmp_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int HOLD_CYCLES = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [7:0]   req_a;
    logic [7:0]   req_b;
    logic [3:0]   ack;
    logic         done;
    logic [1:0]   done_id;
    logic [2:0]   rgb_out;
    logic         busy;
    logic         cmp_a0, cmp_a1, cmp_b0, cmp_b1;
    logic         cmp_r, cmp_g, cmp_b;
    logic         force_bad;
`ifdef RGB_ONEHOT_CHECK_EN
    logic         err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rgb_cmp_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_a   (req_a),
        .req_b   (req_b),
        .ack     (ack),
        .done    (done),
        .done_id (done_id),
        .rgb_out (rgb_out),
        .busy    (busy),
        .cmp_a0  (cmp_a0),
        .cmp_a1  (cmp_a1),
        .cmp_b0  (cmp_b0),
        .cmp_b1  (cmp_b1),
        .cmp_r   (cmp_r),
        .cmp_g   (cmp_g),
        .cmp_b   (cmp_b)
`ifdef RGB_ONEHOT_CHECK_EN
        ,
        .err     (err)
`endif
    );

    // Behavioural comparator; force_bad injects an illegal two-hot result.
    logic [1:0] ma, mb;
    assign ma = {cmp_a1, cmp_a0};
    assign mb = {cmp_b1, cmp_b0};
    always_comb begin
        if (force_bad) begin
            {cmp_r, cmp_g, cmp_b} = 3'b110;
        end else begin
            {cmp_r, cmp_g, cmp_b} = {ma > mb, ma == mb, ma < mb};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; returns the number of edges it took.
    task automatic wait_done(input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                step();
                if (done) begin
                    seen = 1'b1;
                    cyc  = i;
                end
            end
        end
        check(tag, done, 1);
    endtask

    function automatic logic [2:0] exp_rgb(input int a, input int b);
        if (a > b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    initial begin
        int cyc;
        int seen_cnt;
        logic [1:0] rr_exp;

        rst       = 1'b1;
        req       = 4'b1111;
        req_a     = 8'h00;
        req_b     = 8'h00;
        force_bad = 1'b0;

        // ---------------- reset with requests pending ----------------
        step();
        check("rst_outs_c1", {ack, done, done_id, rgb_out, busy, cmp_a1, cmp_a0, cmp_b1, cmp_b0}, 0);
        step();
        check("rst_outs_c2", {ack, done, done_id, rgb_out, busy, cmp_a1, cmp_a0, cmp_b1, cmp_b0}, 0);
`ifdef RGB_ONEHOT_CHECK_EN
        check("rst_err", err, 0);
`endif

        // ---------------- single request on index 2 ----------------
        rst        = 1'b0;
        req        = 4'b0100;
        req_a[5:4] = 2'b10;
        req_b[5:4] = 2'b01;
        step();                                   // cycle 1: DRIVE
        check("single_cmp", {cmp_a1, cmp_a0, cmp_b1, cmp_b0}, 4'b1001);
        check("single_busy_c1", busy, 1);
        check("single_nodone_c1", done, 0);
        req_a[5:4] = 2'b00;                       // must not affect result
        step();                                   // cycle 2: SAMPLE
        check("single_busy_c2", busy, 1);
        check("single_cmp_hold", {cmp_a1, cmp_a0, cmp_b1, cmp_b0}, 4'b1001);
        step();                                   // cycle 3: done
        check("single_done", done, 1);
        check("single_ack", ack, 4'b0100);
        check("single_id", done_id, 2);
        check("single_rgb", rgb_out, 3'b100);
        check("single_busy_c3", busy, 0);
        req = 4'b0000;
        step();
        check("single_done_pulse", {done, ack}, 0);
        check("single_rgb_hold", rgb_out, 3'b100);
        check("single_cmp_idle", {cmp_a1, cmp_a0, cmp_b1, cmp_b0}, 4'b1001);

        // ---------------- round robin, all operands equal ----------------
        rst = 1'b1;
        step();
        rst   = 1'b0;
        req_a = 8'h00;
        req_b = 8'h00;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            rr_exp = 2'(k % 4);
            wait_done("rr_done", cyc);
            check("rr_spacing", cyc, 3);
            check("rr_id", done_id, rr_exp);
            check("rr_ack", ack, 4'b0001 << rr_exp);
            check("rr_rgb", rgb_out, 3'b010);
        end
        req = 4'b0000;
        step();

        // ---------------- operand sweep through requester 1 ----------------
        req = 4'b0010;
        for (int p = 0; p < 16; p++) begin
            req_a[3:2] = 2'(p >> 2);
            req_b[3:2] = 2'(p & 3);
            wait_done("sweep_done", cyc);
            check("sweep_id", done_id, 1);
            check("sweep_rgb", rgb_out, exp_rgb(p >> 2, p & 3));
            if (p == 7) begin
                check("sweep_a1_b3", rgb_out, 3'b001);
            end
        end
        req = 4'b0000;
        step();

        // ---------------- reset during DRIVE ----------------
        req = 4'b1111;
        step();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        req = 4'b0000;
        step();
        rst = 1'b0;
        check("mid_busy_clr", busy, 0);
        check("mid_rgb_clr", rgb_out, 0);
        seen_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || (|ack)) seen_cnt++;
            step();
        end
        check("mid_no_done", seen_cnt, 0);
        check("mid_rgb_stay", rgb_out, 0);
        req = 4'b1111;
        wait_done("mid_next_done", cyc);
        check("mid_next_id", done_id, 0);
        req = 4'b0000;
        step();

`ifdef RGB_ONEHOT_CHECK_EN
        // ---------------- sticky one-hot error ----------------
        check("err_clean", err, 0);
        force_bad = 1'b1;
        req       = 4'b0001;
        wait_done("err_done", cyc);
        check("err_rgb_raw", rgb_out, 3'b110);
        check("err_set", err, 1);
        req       = 4'b0000;
        force_bad = 1'b0;
        step();
        req = 4'b0010;
        wait_done("err_good_done", cyc);
        check("err_sticky", err, 1);
        req = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_rst_clr", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
